// File: rtl/mips_rtype_ctrl.sv
// rtl/mips_rtype_ctrl.sv - multi-cycle R-type/LUI controller for the regfile + clocked ALU datapath
// Optional overflow trap on ADD/SUB write-back: define MIPS_CTRL_OVF_TRAP_EN.
module mips_rtype_ctrl (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] instr,
  input  logic        instr_valid,
  output logic        instr_ready,
  output logic [4:0]  read_reg1,
  output logic [4:0]  read_reg2,
  output logic [4:0]  write_reg,
  output logic        write_enb,
  output logic        mux_ctrl,
  output logic [31:0] imm_data,
  output logic [3:0]  alu_op,
  output logic [4:0]  shift_amt,
  input  logic        alu_overflow,
  output logic        done,
  output logic        illegal,
  output logic        ovf_exc
);

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_LUI   = 6'h0F;

  localparam logic [3:0] ALU_ADD = 4'd0;
  localparam logic [3:0] ALU_SUB = 4'd1;
  localparam logic [3:0] ALU_AND = 4'd2;
  localparam logic [3:0] ALU_OR  = 4'd3;
  localparam logic [3:0] ALU_SLL = 4'd4;
  localparam logic [3:0] ALU_SRL = 4'd5;
  localparam logic [3:0] ALU_SRA = 4'd6;
  localparam logic [3:0] ALU_SLT = 4'd8;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_READ = 3'd1,
    S_WB   = 3'd2,
    S_LUI  = 3'd3,
    S_ILL  = 3'd4
  } state_t;

  state_t state, state_nx;

  logic [5:0]  op, funct;
  logic [4:0]  rs, rt, rd, shamt;
  logic [15:0] imm;

  assign op    = instr[31:26];
  assign rs    = instr[25:21];
  assign rt    = instr[20:16];
  assign rd    = instr[15:11];
  assign shamt = instr[10:6];
  assign funct = instr[5:0];
  assign imm   = instr[15:0];

  logic       dec_rtype, dec_shift, dec_lui;
  logic [3:0] dec_aop;
  logic       accept;
  logic [4:0] rd_q;

  always_comb begin
    dec_rtype = 1'b0;
    dec_shift = 1'b0;
    dec_aop   = ALU_ADD;
    if (op == OP_RTYPE) begin
      dec_rtype = 1'b1;
      case (funct)
        6'h20: dec_aop = ALU_ADD;
        6'h22: dec_aop = ALU_SUB;
        6'h24: dec_aop = ALU_AND;
        6'h25: dec_aop = ALU_OR;
        6'h00: begin dec_aop = ALU_SLL; dec_shift = 1'b1; end
        6'h02: begin dec_aop = ALU_SRL; dec_shift = 1'b1; end
        6'h03: begin dec_aop = ALU_SRA; dec_shift = 1'b1; end
        6'h2A: dec_aop = ALU_SLT;
        default: dec_rtype = 1'b0;
      endcase
    end
  end

  assign dec_lui = (op == OP_LUI);
  assign accept  = (state == S_IDLE) && instr_valid;

  // trap suppresses the WB write and swaps done for ovf_exc
  logic trap;
`ifdef MIPS_CTRL_OVF_TRAP_EN
  logic is_addsub;
  assign is_addsub = (alu_op == ALU_ADD) || (alu_op == ALU_SUB);
  assign trap      = (state == S_WB) && is_addsub && alu_overflow;
`else
  logic unused_ovf;
  assign unused_ovf = alu_overflow;
  assign trap       = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE: begin
        if (instr_valid) begin
          if (dec_rtype)    state_nx = S_READ;
          else if (dec_lui) state_nx = S_LUI;
          else              state_nx = S_ILL;
        end
      end
      S_READ:  state_nx = S_WB;
      S_WB:    state_nx = S_IDLE;
      S_LUI:   state_nx = S_IDLE;
      S_ILL:   state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  logic [4:0]  read_reg1_nx, read_reg2_nx, write_reg_nx, shift_amt_nx, rd_nx;
  logic [3:0]  alu_op_nx;
  logic [31:0] imm_data_nx;
  logic        mux_ctrl_nx, done_nx, illegal_nx, ovf_exc_nx;

  always_comb begin
    instr_ready  = (state == S_IDLE);
    write_enb    = ((state == S_WB) && !trap) || (state == S_LUI);
    read_reg1_nx = read_reg1;
    read_reg2_nx = read_reg2;
    write_reg_nx = write_reg;
    shift_amt_nx = shift_amt;
    alu_op_nx    = alu_op;
    imm_data_nx  = imm_data;
    mux_ctrl_nx  = mux_ctrl;
    rd_nx        = rd_q;
    done_nx      = ((state == S_WB) && !trap) || (state == S_LUI);
    illegal_nx   = (state == S_ILL);
    ovf_exc_nx   = trap;
    if (accept && dec_rtype) begin
      read_reg1_nx = dec_shift ? rt : rs;
      read_reg2_nx = rt;
      alu_op_nx    = dec_aop;
      shift_amt_nx = dec_shift ? shamt : 5'd0;
      rd_nx        = rd;
    end else if (accept && dec_lui) begin
      write_reg_nx = rt;
      mux_ctrl_nx  = 1'b0;
      imm_data_nx  = {imm, 16'h0000};
    end
    // write-back address/select are registered on entry to WB
    if (state == S_READ) begin
      write_reg_nx = rd_q;
      mux_ctrl_nx  = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      read_reg1 <= 5'd0;
      read_reg2 <= 5'd0;
      write_reg <= 5'd0;
      shift_amt <= 5'd0;
      alu_op    <= 4'd0;
      imm_data  <= 32'd0;
      mux_ctrl  <= 1'b0;
      rd_q      <= 5'd0;
      done      <= 1'b0;
      illegal   <= 1'b0;
      ovf_exc   <= 1'b0;
    end else begin
      read_reg1 <= read_reg1_nx;
      read_reg2 <= read_reg2_nx;
      write_reg <= write_reg_nx;
      shift_amt <= shift_amt_nx;
      alu_op    <= alu_op_nx;
      imm_data  <= imm_data_nx;
      mux_ctrl  <= mux_ctrl_nx;
      rd_q      <= rd_nx;
      done      <= done_nx;
      illegal   <= illegal_nx;
      ovf_exc   <= ovf_exc_nx;
    end
  end

endmodule
